phase_seq_ctrl: RTL and testbench
=================================

# phase_seq_ctrl

Programmable five-phase sequencer controller that drives the two 2-bit phase-code outputs (dout0/dout1) of the light-pattern datapath. Per-phase dwell times are loaded through a simple config port, and the block runs the phases on qualified `en` ticks. It adds start, pause and graceful-stop control so a system-level FSM can sequence the pattern instead of letting it free-run.

## Interface
- `CNT_W`, default 3: width of each dwell register and of the tick counter.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `en` in 1: tick qualifier; the dwell counter advances only when high.
- `start` in 1: level; sampled only in IDLE.
- `stop` in 1: level; requests a graceful stop at the end of the current cycle.
- `pause` in 1: level; freezes the sequence while high.
- `cfg_wr` in 1: config write strobe; accepted only when `cfg_rdy`=1.
- `cfg_addr` in 3: phase index 0–4; values 5–7 are ignored.
- `cfg_data` in CNT_W: dwell value in `en` ticks.
- `cfg_rdy` out 1: high in IDLE only.
- `busy` out 1: high in RUN, PAUSE and STOPPING.
- `phase` out 3: current phase index.
- `dout0` out 2: phase code A.
- `dout1` out 2: phase code B.
- `cycle_done` out 1: one-cycle pulse when phase 4 completes.

## Operation
- FSM states: IDLE, RUN, PAUSE, STOPPING.
- Phase code table, (dout0, dout1) per phase: P0 (0,0), P1 (1,1), P2 (1,2), P3 (2,2), P4 (3,3).
- Dwell defaults after reset: P0=1, P1=2, P2=2, P3=2, P4=3.
- Config writes:
  - A write of 0 stores 1 (saturates up).
  - A write while `cfg_rdy`=0 is dropped silently.
- Tick counter `cnt`:
  - Increments on `en` in RUN and STOPPING.
  - When `en` && `cnt`==dwell[phase]−1, the phase ends: `cnt` returns to 0 and `phase` advances, with 4 wrapping to 0.
- Transitions:
  - IDLE→RUN on `start`. `phase` and `cnt` start at 0.
  - RUN→PAUSE on `pause`=1 with `stop`=0. PAUSE→RUN on `pause`=0.
  - RUN or PAUSE→STOPPING on `stop`=1. `stop` has priority over `pause`, and STOPPING ignores `pause`.
  - STOPPING→IDLE when phase 4 ends. `phase` returns to 0.
  - RUN, end of phase 4: `cycle_done` pulses and the sequence continues at P0.
- PAUSE:
  - `cnt`, `phase` and the douts hold.
  - A tick that arrives in the same cycle that `pause` is first sampled high is not counted.
- Dwell values are read live. Because writes happen only in IDLE, they are stable during a run.
- IDLE outputs are the P0 code (0,0).

## Timing
- Reset values: state=IDLE, `cnt`=0, `phase`=0, `dout0`=0, `dout1`=0, `busy`=0, `cycle_done`=0, `cfg_rdy`=1, dwell registers at the defaults. Reset has priority over every input.
- All outputs are registered. `phase`, `dout0` and `dout1` update on the same edge, so they are always mutually consistent.
- If `start` is sampled at edge N:
  - `busy`=1 and `cfg_rdy`=0 after edge N.
  - The first tick is counted at edge N+1 or later.
- `cycle_done` is high for exactly the one cycle after the edge where phase 4 ends, and coincides with `phase`=0.
- With `en` held at 1 and default dwells, one full cycle is 10 clocks: P0 for 1, P1 for 2, P2 for 2, P3 for 2, P4 for 3.
- A config write at edge N is visible to a `start` sampled at edge N+1.
- `start` and `cfg_wr` in the same IDLE cycle: the write completes and the run starts.
- Reset mid-run returns the block to IDLE in the next cycle; any partial cycle is discarded and dwell values return to the defaults.

## Configuration
- `PHASE_SEQ_ONESHOT_EN`:
  - Defined: RUN behaves as STOPPING. After one full cycle the block returns to IDLE with `cycle_done` pulsed.
  - Undefined: RUN loops until `stop` is asserted.

## Test plan
- Reset, then `start` with `en`=1 and default dwells → (dout0,dout1) sequence per clock: (0,0)×1, (1,1)×2, (1,2)×2, (2,2)×2, (3,3)×3. `cycle_done` pulses with `phase`=0 on clock 11.
- Write P1=5 and P4=0, then run → P1 lasts 5 ticks and P4 lasts 1 tick. A write attempted while `busy` leaves the dwells unchanged.
- `en` toggling 1/0 → every phase lasts 2× its dwell in clocks. Hold `pause` for 4 clocks in the middle of P2 → `phase` and `cnt` are frozen, then P2 resumes for its remaining ticks.
- Assert `stop` during P1 of a cycle → the block finishes P1–P4 and enters IDLE with (0,0), `busy`=0, `cfg_rdy`=1. `stop` and `pause` asserted together → STOPPING and continued counting.
- Assert `rst` during P3 → on the next clock all outputs are at their reset values and the dwells are at the defaults.
- Build with `PHASE_SEQ_ONESHOT_EN` and `start`, no `stop` → exactly one 10-clock cycle runs, then IDLE. Build without it → the cycle repeats until `stop`.

Source files
------------

// File: rtl/phase_seq_ctrl.sv
// phase_seq_ctrl: programmable five-phase sequencer controller.
//
// Runs phases P0..P4 on qualified en ticks; each phase lasts dwell[phase]
// ticks. Dwell registers are written through the config port while idle.
// Start, pause and graceful stop let a system FSM sequence the pattern.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                tick qualifier for the dwell counter
//   start             level, sampled only in IDLE
//   stop              level, graceful stop at end of current cycle
//   pause             level, freezes the sequence while high
//   cfg_wr/addr/data  dwell write (addr 0-4, others ignored; 0 stores 1)
//   cfg_rdy           high in IDLE only
//   busy              high in RUN, PAUSE, STOPPING
//   phase             current phase index
//   dout0, dout1      phase codes A and B
//   cycle_done        one-cycle pulse when phase 4 completes
//
// Build option: PHASE_SEQ_ONESHOT_EN makes RUN end in IDLE after one cycle.
module phase_seq_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             cfg_rdy,
    output logic             busy,
    output logic [2:0]       phase,
    output logic [1:0]       dout0,
    output logic [1:0]       dout1,
    output logic             cycle_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

`ifdef PHASE_SEQ_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic [1:0]       state, state_nx;
    logic [2:0]       phase_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] dwell [5];
    logic [CNT_W-1:0] dwell_cur;
    logic             tick;
    logic             done_nx;

    function automatic logic [1:0] code_a(input logic [2:0] p);
        case (p)
            3'd1, 3'd2: code_a = 2'd1;
            3'd3:       code_a = 2'd2;
            3'd4:       code_a = 2'd3;
            default:    code_a = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] code_b(input logic [2:0] p);
        case (p)
            3'd1:       code_b = 2'd1;
            3'd2, 3'd3: code_b = 2'd2;
            3'd4:       code_b = 2'd3;
            default:    code_b = 2'd0;
        endcase
    endfunction

    always_comb begin
        case (phase)
            3'd1:    dwell_cur = dwell[1];
            3'd2:    dwell_cur = dwell[2];
            3'd3:    dwell_cur = dwell[3];
            3'd4:    dwell_cur = dwell[4];
            default: dwell_cur = dwell[0];
        endcase
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        tick     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    phase_nx = 3'd0;
                    cnt_nx   = '0;
                end
            end
            S_RUN: begin
                // stop outranks pause; the tick of the pause-entry cycle is dropped
                if (stop) begin
                    state_nx = S_STOP;
                    tick     = en;
                end else if (pause) begin
                    state_nx = S_PAUSE;
                end else begin
                    tick = en;
                end
            end
            S_PAUSE: begin
                if (stop)
                    state_nx = S_STOP;
                else if (!pause)
                    state_nx = S_RUN;
            end
            default: begin
                tick = en;
            end
        endcase

        if (tick) begin
            if (cnt == dwell_cur - CNT_W'(1)) begin
                cnt_nx = '0;
                if (phase == 3'd4) begin
                    phase_nx = 3'd0;
                    done_nx  = 1'b1;
                    // a stop sampled in this same cycle also ends the run here
                    if (state_nx == S_STOP || ONESHOT)
                        state_nx = S_IDLE;
                end else begin
                    phase_nx = phase + 3'd1;
                end
            end else begin
                cnt_nx = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase      <= 3'd0;
            cnt        <= '0;
            dout0      <= 2'd0;
            dout1      <= 2'd0;
            busy       <= 1'b0;
            cfg_rdy    <= 1'b1;
            cycle_done <= 1'b0;
            dwell[0]   <= CNT_W'(1);
            dwell[1]   <= CNT_W'(2);
            dwell[2]   <= CNT_W'(2);
            dwell[3]   <= CNT_W'(2);
            dwell[4]   <= CNT_W'(3);
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            cnt        <= cnt_nx;
            dout0      <= code_a(phase_nx);
            dout1      <= code_b(phase_nx);
            busy       <= (state_nx != S_IDLE);
            cfg_rdy    <= (state_nx == S_IDLE);
            cycle_done <= done_nx;
            if (state == S_IDLE && cfg_wr) begin
                for (int unsigned i = 0; i < 5; i++) begin
                    if (cfg_addr == 3'(i))
                        dwell[i] <= (cfg_data == '0) ? CNT_W'(1) : cfg_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// tb_phase_seq_ctrl: self-checking bench for phase_seq_ctrl.
// A directed default-cycle run is checked against a fixed code table, then
// randomized control/config traffic is checked every clock against a
// behavioural model that tracks phase progress as elapsed ticks per phase.
module tb_phase_seq_ctrl;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst, en, start, stop, pause, cfg_wr;
    logic [2:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_data;
    logic             cfg_rdy, busy, cycle_done;
    logic [2:0]       phase;
    logic [1:0]       dout0, dout1;

    int checks = 0;
    int errors = 0;

    phase_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .pause(pause), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_rdy(cfg_rdy), .busy(busy),
        .phase(phase), .dout0(dout0), .dout1(dout1),
        .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 running, 2 paused, 3 stopping
    int m_mode, m_phase, m_elapsed, m_done;
    int m_dwell [5];
    int code_a [5] = '{0, 1, 1, 2, 3};
    int code_b [5] = '{0, 1, 2, 2, 3};
`ifdef PHASE_SEQ_ONESHOT_EN
    bit oneshot = 1'b1;
`else
    bit oneshot = 1'b0;
`endif

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_elapsed = 0; m_done = 0;
        m_dwell = '{1, 2, 2, 2, 3};
    endtask

    task automatic model_step();
        bit counts;
        bit stopping;
        m_done = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_mode == 0) begin
            if (cfg_wr && cfg_addr < 5)
                m_dwell[cfg_addr] = (cfg_data == 0) ? 1 : int'(cfg_data);
            if (start) begin
                m_mode = 1; m_phase = 0; m_elapsed = 0;
            end
            return;
        end
        counts = (m_mode == 3) || (m_mode == 1 && (stop || !pause));
        if ((m_mode == 1 || m_mode == 2) && stop) m_mode = 3;
        else if (m_mode == 1 && pause)            m_mode = 2;
        else if (m_mode == 2 && !pause)           m_mode = 1;
        stopping = (m_mode == 3) || oneshot;
        if (counts && en) begin
            m_elapsed++;
            if (m_elapsed >= m_dwell[m_phase]) begin
                m_elapsed = 0;
                if (m_phase == 4) begin
                    m_phase = 0;
                    m_done = 1;
                    if (stopping) m_mode = 0;
                end else begin
                    m_phase++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("phase",      int'(phase),      m_phase);
        check("dout0",      int'(dout0),      code_a[m_phase]);
        check("dout1",      int'(dout1),      code_b[m_phase]);
        check("busy",       int'(busy),       int'(m_mode != 0));
        check("cfg_rdy",    int'(cfg_rdy),    int'(m_mode == 0));
        check("cycle_done", int'(cycle_done), m_done);
    endtask

    task automatic cycle(input logic r, input logic e, input logic s,
                         input logic sp, input logic p, input logic w,
                         input logic [2:0] a, input logic [CNT_W-1:0] d);
        @(negedge clk);
        rst = r; en = e; start = s; stop = sp; pause = p;
        cfg_wr = w; cfg_addr = a; cfg_data = d;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int exp_a [10] = '{0, 1, 1, 1, 1, 2, 2, 3, 3, 3};
        int exp_b [10] = '{0, 1, 1, 2, 2, 2, 2, 3, 3, 3};
        logic p_lvl;
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();

        // reset state
        cycle(1, 0, 0, 0, 0, 0, 3'd0, 3'd0);
        cycle(1, 0, 0, 0, 0, 0, 3'd0, 3'd0);

        // default dwells, en held high: fixed code sequence
        cycle(0, 1, 1, 0, 0, 0, 3'd0, 3'd0);
        check("seq_busy", int'(busy), 1);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cycle(0, 1, 0, 0, 0, 0, 3'd0, 3'd0);
            check("seq_dout0", int'(dout0), exp_a[k]);
            check("seq_dout1", int'(dout1), exp_b[k]);
            check("seq_done0", int'(cycle_done), 0);
        end
        cycle(0, 1, 0, 0, 0, 0, 3'd0, 3'd0);
        check("seq_done", int'(cycle_done), 1);
        check("seq_wrap", int'(phase), 0);

        // graceful stop, then reconfigure P1=5, P4=0 and run again
        for (int k = 0; k < 12; k++) cycle(0, 1, 0, (k == 1), 0, 0, 3'd0, 3'd0);
        check("stop_idle", int'(cfg_rdy), 1);
        cycle(0, 0, 0, 0, 0, 1, 3'd1, 3'd5);
        cycle(0, 0, 0, 0, 0, 1, 3'd4, 3'd0);
        cycle(0, 0, 1, 0, 0, 1, 3'd7, 3'd6);
        for (int k = 0; k < 30; k++)
            cycle(0, (k % 2 == 0), 0, (k == 20), (k >= 8 && k < 12), 1,
                  3'(k % 5), 3'(k));

        // mid-run reset
        cycle(0, 1, 1, 0, 0, 0, 3'd0, 3'd0);
        for (int k = 0; k < 6; k++) cycle(0, 1, 0, 0, 0, 0, 3'd0, 3'd0);
        cycle(1, 1, 0, 0, 0, 0, 3'd0, 3'd0);
        check("rst_phase", int'(phase), 0);
        check("rst_busy", int'(busy), 0);

        // randomized traffic
        p_lvl = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(7) == 0) p_lvl = ~p_lvl;
            cycle(($urandom_range(299) == 0),
                  ($urandom_range(3) != 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(39) == 0),
                  p_lvl,
                  ($urandom_range(2) == 0),
                  3'($urandom_range(7)),
                  CNT_W'($urandom_range(7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
